// File: rtl/i2s_rx.sv
// i2s_rx: I2S capture end of the codec audio link.
// Oversamples the I2S bit clock, word select and serial data in the system
// clock domain, rebuilds left/right sample words (MSB first, one-bit delay
// after each word-select change) and presents one registered left/right pair
// per good frame with a single-cycle strobe. Slots whose length differs from
// SLOT_W bit clocks are flagged with a single-cycle frame_err pulse.
module i2s_rx #(
   parameter int DATA_W = 24,
   parameter int SLOT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              aud_bclk,
   input  logic              aud_lrc,
   input  logic              aud_adcdat,
   output logic [DATA_W-1:0] left_data,
   output logic [DATA_W-1:0] right_data,
   output logic              sample_valid,
   output logic              frame_err
);

   typedef enum logic [1:0] {
      ST_HUNT  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } state_e;

   // Slot counter saturates here so an idle link never wraps into a false match.
   localparam logic [5:0] CNT_MAX  = 6'd63;
   localparam logic [5:0] SLOT_CNT = 6'(SLOT_W);
   // Count value on the edge that shifts in the last data bit of a slot.
   localparam logic [5:0] LAST_BIT = 6'(DATA_W + 1);

   // Synchronizer stages; all three inputs share the same depth so data and
   // word select stay aligned with the detected bit-clock edge.
   logic bclk_s1_q;
   logic bclk_s2_q;
   logic bclk_d_q;
   logic lrc_s1_q;
   logic lrc_s2_q;
   logic dat_s1_q;
   logic dat_s2_q;

   // Frame tracking state.
   state_e            state_q;
   logic              lrc_prev_q;
   logic [5:0]        slot_cnt_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] left_hold_q;
   logic              left_ok_q;

   // Registered outputs.
   logic [DATA_W-1:0] left_data_q;
   logic [DATA_W-1:0] right_data_q;
   logic              sample_valid_q;
   logic              frame_err_q;

   // Combinational helpers.
   logic              bclk_rise_s;
   logic              lrc_chg_s;
   logic [5:0]        cnt_inc_s;
   logic [5:0]        bit_idx_s;
   logic              shift_en_s;
   logic [DATA_W-1:0] shreg_d;

   // Two-flop synchronizers for all inputs plus the bclk edge-detect delay flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bclk_s1_q <= 1'b0;
         bclk_s2_q <= 1'b0;
         bclk_d_q  <= 1'b0;
         lrc_s1_q  <= 1'b0;
         lrc_s2_q  <= 1'b0;
         dat_s1_q  <= 1'b0;
         dat_s2_q  <= 1'b0;
      end else begin
         bclk_s1_q <= aud_bclk;
         bclk_s2_q <= bclk_s1_q;
         bclk_d_q  <= bclk_s2_q;
         lrc_s1_q  <= aud_lrc;
         lrc_s2_q  <= lrc_s1_q;
         dat_s1_q  <= aud_adcdat;
         dat_s2_q  <= dat_s1_q;
      end
   end

   // Edge detect, saturating slot count and positional insert of the next data bit.
   // Bits are written by position (MSB at count 2) into a word cleared on every
   // word-select change, which is equivalent to an MSB-first shift register.
   always_comb begin
      bclk_rise_s = bclk_s2_q & ~bclk_d_q;
      lrc_chg_s   = lrc_s2_q ^ lrc_prev_q;
      if (slot_cnt_q == CNT_MAX) begin
         cnt_inc_s = CNT_MAX;
      end else begin
         cnt_inc_s = slot_cnt_q + 6'd1;
      end
      bit_idx_s  = LAST_BIT - cnt_inc_s;
      shift_en_s = (cnt_inc_s >= 6'd2) && (cnt_inc_s <= LAST_BIT);
      shreg_d    = shreg_q;
      for (int i = 0; i < DATA_W; i++) begin
         if (bit_idx_s == 6'(i)) begin
            shreg_d[i] = dat_s2_q;
         end else begin
            shreg_d[i] = shreg_q[i];
         end
      end
   end

   // Slot tracking FSM: slot counting, length check, word assembly and output pairing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_HUNT;
         lrc_prev_q     <= 1'b0;
         slot_cnt_q     <= 6'd0;
         shreg_q        <= {DATA_W{1'b0}};
         left_hold_q    <= {DATA_W{1'b0}};
         left_ok_q      <= 1'b0;
         left_data_q    <= {DATA_W{1'b0}};
         right_data_q   <= {DATA_W{1'b0}};
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
         if (bclk_rise_s) begin
            lrc_prev_q <= lrc_s2_q;
            if (lrc_chg_s) begin
               // Change edge: carries the previous channel's LSB, never shifted in.
               slot_cnt_q <= 6'd1;
               shreg_q    <= {DATA_W{1'b0}};
               case (state_q)
                  ST_HUNT: begin
                     left_ok_q <= 1'b0;
                  end
                  ST_LEFT, ST_RIGHT: begin
                     if (slot_cnt_q != SLOT_CNT) begin
                        frame_err_q <= 1'b1;
                        left_ok_q   <= 1'b0;
                     end else begin
                        left_ok_q <= left_ok_q;
                     end
                  end
                  default: begin
                     left_ok_q <= 1'b0;
                  end
               endcase
               state_q <= lrc_s2_q ? ST_RIGHT : ST_LEFT;
            end else begin
               slot_cnt_q <= cnt_inc_s;
               if ((state_q != ST_HUNT) && shift_en_s) begin
                  shreg_q <= shreg_d;
               end
               if (cnt_inc_s == LAST_BIT) begin
                  case (state_q)
                     ST_LEFT: begin
                        left_hold_q <= shreg_d;
                        left_ok_q   <= 1'b1;
                     end
                     ST_RIGHT: begin
                        // A right word only pairs with a good left word from this frame.
                        if (left_ok_q) begin
                           left_data_q    <= left_hold_q;
                           right_data_q   <= shreg_d;
                           sample_valid_q <= 1'b1;
                           left_ok_q      <= 1'b0;
                        end
                     end
                     default: begin
                        left_ok_q <= 1'b0;
                     end
                  endcase
               end
            end
         end
      end
   end

   assign left_data    = left_data_q;
   assign right_data   = right_data_q;
   assign sample_valid = sample_valid_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench for i2s_rx. Drives an I2S stream at clk/32 into a
// 24-bit and a 16-bit instance; expected pairs are queued as frames are sent
// and compared when each instance strobes sample_valid.
module tb_i2s_rx;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bclk = 1'b0;
   logic lrc = 1'b0;
   logic dat = 1'b0;

   logic [23:0] l24, r24;
   logic        sv24, fe24;
   logic [15:0] l16, r16;
   logic        sv16, fe16;

   always #5 clk = ~clk;

   i2s_rx #(.DATA_W(24), .SLOT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .aud_bclk(bclk), .aud_lrc(lrc), .aud_adcdat(dat),
      .left_data(l24), .right_data(r24), .sample_valid(sv24), .frame_err(fe24)
   );

   i2s_rx #(.DATA_W(16), .SLOT_W(32)) dut16 (
      .clk(clk), .rst_n(rst_n), .aud_bclk(bclk), .aud_lrc(lrc), .aud_adcdat(dat),
      .left_data(l16), .right_data(r16), .sample_valid(sv16), .frame_err(fe16)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulses24 = 0, pulses16 = 0, errs24 = 0, errs16 = 0;
   int last_pulse_cyc = 0, prev_pulse_cyc = 0;
   logic [47:0] q24[$];
   logic [31:0] q16[$];
   logic [47:0] exp24;
   logic [31:0] exp16;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard for the 24-bit instance.
   always @(negedge clk) begin
      if (fe24) errs24++;
      if (sv24) begin
         pulses24++;
         prev_pulse_cyc = last_pulse_cyc;
         last_pulse_cyc = cyc;
         checks++;
         if (fe24 !== 1'b0) begin
            failures++;
            $display("FAIL overlap24 frame_err=%b required=0 with sample_valid", fe24);
         end
         checks++;
         if (q24.size() == 0) begin
            failures++;
            $display("FAIL pair24 unexpected pulse got=%h/%h required=none", l24, r24);
         end else begin
            exp24 = q24.pop_front();
            if ({l24, r24} !== exp24) begin
               failures++;
               $display("FAIL pair24 got=%h/%h required=%h/%h", l24, r24, exp24[47:24], exp24[23:0]);
            end
         end
      end
   end

   // Scoreboard for the 16-bit instance.
   always @(negedge clk) begin
      if (fe16) errs16++;
      if (sv16) begin
         pulses16++;
         checks++;
         if (q16.size() == 0) begin
            failures++;
            $display("FAIL pair16 unexpected pulse got=%h/%h required=none", l16, r16);
         end else begin
            exp16 = q16.pop_front();
            if ({l16, r16} !== exp16) begin
               failures++;
               $display("FAIL pair16 got=%h/%h required=%h/%h", l16, r16, exp16[31:16], exp16[15:0]);
            end
         end
      end
   end

   function automatic logic slot_bit(input logic [31:0] w, input int k);
      if (k == 0) return 1'b0;
      else if (k <= 31) return w[32-k];
      else return logic'($urandom_range(1, 0));
   endfunction

   // One bit clock period: drive on the falling edge, 16 clk low then 16 clk high.
   task automatic bit_period(input logic lv, input logic dv);
      bclk = 1'b0;
      lrc  = lv;
      dat  = dv;
      repeat (16) @(posedge clk);
      #1 bclk = 1'b1;
      repeat (16) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic lv, input logic [31:0] w, input int first, input int last);
      for (int k = first; k <= last; k++) bit_period(lv, slot_bit(w, k));
   endtask

   task automatic push_pair(input logic [31:0] lw, input logic [31:0] rw);
      q24.push_back({lw[31:8], rw[31:8]});
      q16.push_back({lw[31:16], rw[31:16]});
   endtask

   task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input bit push);
      send_bits(1'b0, lw, 0, 31);
      if (push) push_pair(lw, rw);
      send_bits(1'b1, rw, 0, 31);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (l24 !== 24'h0 || r24 !== 24'h0) begin
         failures++;
         $display("FAIL reset_data got=%h/%h required=0/0", l24, r24);
      end
      checks++;
      if (sv24 !== 1'b0 || fe24 !== 1'b0) begin
         failures++;
         $display("FAIL reset_pulses got=%b/%b required=0/0", sv24, fe24);
      end
      checks++;
      if (l16 !== 16'h0 || r16 !== 16'h0 || sv16 !== 1'b0 || fe16 !== 1'b0) begin
         failures++;
         $display("FAIL reset16 got=%h/%h/%b/%b required=0", l16, r16, sv16, fe16);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_nominal();
      int p0, e0;
      p0 = pulses24;
      e0 = errs24;
      send_frame(32'hABCDEF00, 32'h12345600, 1'b0);
      checks++;
      if (pulses24 !== p0) begin
         failures++;
         $display("FAIL nominal_first_frame pulses=%0d required=%0d", pulses24 - p0, 0);
      end
      send_frame(32'hABCDEF00, 32'h12345600, 1'b1);
      send_frame(32'hABCDEF00, 32'h12345600, 1'b1);
      checks++;
      if (pulses24 !== p0 + 2) begin
         failures++;
         $display("FAIL nominal_count pulses=%0d required=2", pulses24 - p0);
      end
      checks++;
      if (l24 !== 24'hABCDEF || r24 !== 24'h123456) begin
         failures++;
         $display("FAIL nominal_hold got=%h/%h required=abcdef/123456", l24, r24);
      end
      checks++;
      if (errs24 !== e0) begin
         failures++;
         $display("FAIL nominal_err errs=%0d required=0", errs24 - e0);
      end
   endtask

   task automatic test_back_to_back();
      int p0;
      p0 = pulses24;
      send_frame(32'h80000000, 32'h7FFFFF00, 1'b1);
      send_frame(32'h00000100, 32'hFFFFFF00, 1'b1);
      checks++;
      if (pulses24 !== p0 + 2) begin
         failures++;
         $display("FAIL b2b_count pulses=%0d required=2", pulses24 - p0);
      end
      checks++;
      if (last_pulse_cyc - prev_pulse_cyc !== 2048) begin
         failures++;
         $display("FAIL b2b_spacing clks=%0d required=2048", last_pulse_cyc - prev_pulse_cyc);
      end
      checks++;
      if (l24 !== 24'h000001 || r24 !== 24'hFFFFFF) begin
         failures++;
         $display("FAIL b2b_hold got=%h/%h required=000001/ffffff", l24, r24);
      end
   endtask

   task automatic test_short_slot();
      int p0, e0;
      p0 = pulses24;
      e0 = errs24;
      send_bits(1'b0, 32'hCAFE1200, 0, 19);
      send_bits(1'b1, 32'h33333300, 0, 31);
      checks++;
      if (errs24 !== e0 + 1 || errs16 !== errs24) begin
         failures++;
         $display("FAIL short_err errs24=%0d errs16=%0d required=%0d", errs24, errs16, e0 + 1);
      end
      checks++;
      if (pulses24 !== p0) begin
         failures++;
         $display("FAIL short_no_pulse pulses=%0d required=0", pulses24 - p0);
      end
      send_frame(32'h5A5A5A00, 32'hA5A5A500, 1'b1);
      checks++;
      if (pulses24 !== p0 + 1 || errs24 !== e0 + 1) begin
         failures++;
         $display("FAIL short_recover pulses=%0d errs=%0d required=1/1", pulses24 - p0, errs24 - e0);
      end
   endtask

   task automatic test_long_slot();
      int p0, e0;
      p0 = pulses24;
      e0 = errs24;
      send_bits(1'b0, 32'h13579B00, 0, 31);
      push_pair(32'h13579B00, 32'h2468AC00);
      send_bits(1'b1, 32'h2468AC00, 0, 39);
      checks++;
      if (pulses24 !== p0 + 1 || errs24 !== e0) begin
         failures++;
         $display("FAIL long_pre pulses=%0d errs=%0d required=1/0", pulses24 - p0, errs24 - e0);
      end
      send_bits(1'b0, 32'h11111100, 0, 31);
      checks++;
      if (errs24 !== e0 + 1) begin
         failures++;
         $display("FAIL long_err errs=%0d required=1", errs24 - e0);
      end
      checks++;
      if (l24 !== 24'h13579B || r24 !== 24'h2468AC) begin
         failures++;
         $display("FAIL long_hold got=%h/%h required=13579b/2468ac", l24, r24);
      end
      push_pair(32'h11111100, 32'h22222200);
      send_bits(1'b1, 32'h22222200, 0, 31);
      checks++;
      if (pulses24 !== p0 + 2) begin
         failures++;
         $display("FAIL long_recover pulses=%0d required=2", pulses24 - p0);
      end
   endtask

   task automatic test_reset_mid();
      int p0, e0;
      send_bits(1'b0, 32'hDEAD0000, 0, 9);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (l24 !== 24'h0 || r24 !== 24'h0 || sv24 !== 1'b0 || fe24 !== 1'b0) begin
         failures++;
         $display("FAIL midreset_out got=%h/%h/%b/%b required=0", l24, r24, sv24, fe24);
      end
      checks++;
      if (l16 !== 16'h0 || r16 !== 16'h0) begin
         failures++;
         $display("FAIL midreset_out16 got=%h/%h required=0/0", l16, r16);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      p0 = pulses24;
      e0 = errs24;
      send_bits(1'b0, 32'hDEAD0000, 10, 31);
      send_bits(1'b1, 32'hBEEF0000, 0, 31);
      checks++;
      if (pulses24 !== p0) begin
         failures++;
         $display("FAIL midreset_partial pulses=%0d required=0", pulses24 - p0);
      end
      send_frame(32'h0F0F0F00, 32'hF0F0F000, 1'b1);
      checks++;
      if (pulses24 !== p0 + 1 || errs24 !== e0) begin
         failures++;
         $display("FAIL midreset_first pulses=%0d errs=%0d required=1/0", pulses24 - p0, errs24 - e0);
      end
   endtask

   task automatic test_width16();
      int p0;
      p0 = pulses16;
      send_frame(32'hBEEFA5C3, 32'h12345A3C, 1'b1);
      checks++;
      if (pulses16 !== p0 + 1) begin
         failures++;
         $display("FAIL w16_count pulses=%0d required=1", pulses16 - p0);
      end
      checks++;
      if (l16 !== 16'hBEEF || r16 !== 16'h1234) begin
         failures++;
         $display("FAIL w16_data got=%h/%h required=beef/1234", l16, r16);
      end
      checks++;
      if (l24 !== 24'hBEEFA5 || r24 !== 24'h12345A) begin
         failures++;
         $display("FAIL w16_wide got=%h/%h required=beefa5/12345a", l24, r24);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_back_to_back();
      test_short_slot();
      test_long_slot();
      test_reset_mid();
      test_width16();
      repeat (4) @(posedge clk);
      checks++;
      if (q24.size() != 0 || q16.size() != 0) begin
         failures++;
         $display("FAIL pending_pairs q24=%0d q16=%0d required=0/0", q24.size(), q16.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
